iob_cache_tgen: RTL and testbench

Synthesizable traffic generator and checker for the iob_cache front-end native interface. Drives parametrised write/read sequences (word, byte-lane, read-only and write-then-readback modes) over a programmable word-address window. Checks read data against a deterministic pattern, counts mismatches and flags handshake timeouts. Sits in place of the hand-written stimulus in cache benches and in on-chip self-test wrappers, in front of iob_cache / iob_cache_axi.

---
 rtl/iob_cache_tgen.sv | 256 +++++++++++++++++++++++++
 tb/tb_iob_cache_tgen.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_tgen.sv
// Traffic generator/checker for the iob_cache native front-end: issues word, byte-lane,
// read-only or write-then-readback sequences over a word-address window and checks read data.
module iob_cache_tgen #(
  parameter int FE_ADDR_W = 32,
  parameter int FE_DATA_W = 32,
  parameter int CNT_W     = 8,
  parameter int ERR_W     = 16,
  parameter int TIMEOUT_W = 10
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     start_i,
  input  logic [1:0]                               mode_i,
  input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0] base_i,
  input  logic [CNT_W-1:0]                         count_i,
  output logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0] addr_o,
  output logic [FE_DATA_W-1:0]                     wdata_o,
  output logic [FE_DATA_W/8-1:0]                   wstrb_o,
  output logic                                     valid_o,
  input  logic [FE_DATA_W-1:0]                     rdata_i,
  input  logic                                     ready_i,
  output logic                                     busy_o,
  output logic                                     done_o,
  output logic                                     timeout_o,
  output logic [ERR_W-1:0]                         err_cnt_o,
  output logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0] first_err_addr_o,
  output logic [FE_DATA_W-1:0]                     first_err_data_o
);
  localparam int NB     = FE_DATA_W / 8;
  localparam int AW     = FE_ADDR_W - $clog2(NB);
  localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NB - 1);

  localparam logic [1:0] M_WORD = 2'd0;
  localparam logic [1:0] M_BYTE = 2'd1;
  localparam logic [1:0] M_READ = 2'd2;
  localparam logic [1:0] M_RAW  = 2'd3;

  // state | meaning
  // IDLE  | waiting for start
  // REQ   | request presented, waiting for ready or timeout
  // GAP   | one idle cycle between requests; pointer already at next transaction
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [AW-1:0]         base_q, base_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic                  rd_q, rd_d;
  logic                  last_q, last_d;
  logic [TIMEOUT_W-1:0]  tmr_q, tmr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [FE_DATA_W-1:0]  wdata_q, wdata_d;
  logic [NB-1:0]         wstrb_q, wstrb_d;
  logic                  valid_q, busy_q, done_q;
  logic                  timeout_q, timeout_d;
  logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
  logic [AW-1:0]         ferr_addr_q, ferr_addr_d;
  logic [FE_DATA_W-1:0]  ferr_data_q, ferr_data_d;

  logic                  load_req;
  logic                  is_end;
  logic [FE_DATA_W-1:0]  exp_data;

  function automatic logic [FE_DATA_W-1:0] pat_w(input logic [CNT_W-1:0] i);
    logic [CNT_W:0] s;
    s = {1'b0, i} + (CNT_W+1)'(1);
    return FE_DATA_W'(s);
  endfunction

  function automatic logic [FE_DATA_W-1:0] pat_b(input logic [CNT_W-1:0] i);
    logic [7:0] b;
    b = 8'(i);
    return {NB{b}};
  endfunction

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    base_d      = base_q;
    count_d     = count_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    rd_d        = rd_q;
    last_d      = last_q;
    tmr_d       = tmr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    timeout_d   = timeout_q;
    err_cnt_d   = err_cnt_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    load_req    = 1'b0;
    is_end      = (idx_q == count_q - CNT_W'(1));
    exp_data    = (mode_q == M_BYTE) ? pat_b(idx_q) : pat_w(idx_q);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d      = mode_i;
          base_d      = base_i;
          count_d     = count_i;
          idx_d       = '0;
          lane_d      = '0;
          rd_d        = (mode_i == M_READ);
          last_d      = 1'b0;
          timeout_d   = 1'b0;
          err_cnt_d   = '0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
          if (count_i == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_REQ;
            load_req = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (ready_i) begin
          state_d = S_GAP;
          if (wstrb_q == '0 && rdata_i != exp_data) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (err_cnt_q == '0) begin
              ferr_addr_d = addr_q;
              ferr_data_d = rdata_i;
            end
          end
          // Advance the pointer to the transaction that follows this one.
          if (rd_q) begin
            if (is_end) begin
              last_d = 1'b1;
            end else begin
              idx_d = idx_q + CNT_W'(1);
              if (mode_q == M_RAW) rd_d = 1'b0;
            end
          end else begin
            case (mode_q)
              M_RAW: rd_d = 1'b1;
              M_BYTE: begin
                if (lane_q != LANE_LAST) begin
                  lane_d = lane_q + LANE_W'(1);
                end else begin
                  lane_d = '0;
                  if (is_end) begin
                    rd_d  = 1'b1;
                    idx_d = '0;
                  end else begin
                    idx_d = idx_q + CNT_W'(1);
                  end
                end
              end
              default: begin
                if (is_end) begin
                  rd_d  = 1'b1;
                  idx_d = '0;
                end else begin
                  idx_d = idx_q + CNT_W'(1);
                end
              end
            endcase
          end
        end else if (tmr_q == TIMEOUT_W'(1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          tmr_d = tmr_q - TIMEOUT_W'(1);
        end
      end
      S_GAP: begin
        if (last_q) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_REQ;
          load_req = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_req) begin
      tmr_d  = '1;
      addr_d = base_d + AW'(idx_d);
      if (rd_d) begin
        wstrb_d = '0;
        wdata_d = '0;
      end else if (mode_d == M_BYTE) begin
        wstrb_d = NB'(1) << lane_d;
        wdata_d = pat_b(idx_d);
      end else begin
        wstrb_d = '1;
        wdata_d = pat_w(idx_d);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      base_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      rd_q        <= 1'b0;
      last_q      <= 1'b0;
      tmr_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      rd_q        <= rd_d;
      last_q      <= last_d;
      tmr_q       <= tmr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      valid_q     <= (state_d == S_REQ);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
    end
  end

  assign addr_o           = addr_q;
  assign wdata_o          = wdata_q;
  assign wstrb_o          = wstrb_q;
  assign valid_o          = valid_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign timeout_o        = timeout_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = ferr_addr_q;
  assign first_err_data_o = ferr_data_q;

endmodule

// File: tb/tb_iob_cache_tgen.sv
// Bench for iob_cache_tgen: byte-lane memory responder with programmable ready latency,
// expected requests and end-of-sequence status pushed into queues and checked by a monitor.
module tb_iob_cache_tgen;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam logic [1:0] M_WORD = 2'd0, M_BYTE = 2'd1, M_READ = 2'd2, M_RAW = 2'd3;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [1:0]    mode_i = '0;
  logic [AW-1:0] base_i = '0;
  logic [7:0]    count_i = '0;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [NB-1:0] wstrb_o;
  logic          valid_o;
  logic [DW-1:0] rdata_i = '0;
  logic          ready_i = 1'b0;
  logic          busy_o, done_o, timeout_o;
  logic [1:0]    err_cnt_o;
  logic [AW-1:0] first_err_addr_o;
  logic [DW-1:0] first_err_data_o;

  iob_cache_tgen #(
    .FE_ADDR_W(32), .FE_DATA_W(32), .CNT_W(8), .ERR_W(2), .TIMEOUT_W(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .base_i(base_i), .count_i(count_i), .addr_o(addr_o), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .valid_o(valid_o), .rdata_i(rdata_i), .ready_i(ready_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o), .first_err_data_o(first_err_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d; logic [NB-1:0] s;} txn_t;
  typedef struct {int cyc; int vc; logic [1:0] err; logic [AW-1:0] fa; logic [DW-1:0] fd; logic to;} res_t;

  txn_t exp_q[$];
  res_t res_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];

  int checks = 0;
  int errors = 0;
  int ncyc = 0, t_start = 0, vcnt = 0, lat = 0, done_seen = 0;
  int lat_l = 1;
  bit no_ready = 0, spurious = 0;
  bit h_vld = 0;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic [NB-1:0] h_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_w(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    txn_t t;
    t.a = a; t.d = d; t.s = s;
    exp_q.push_back(t);
  endtask

  task automatic push_r(input logic [AW-1:0] a);
    push_w(a, '0, '0);
  endtask

  task automatic push_res(input int cyc, input int vc, input logic [1:0] err,
                          input logic [AW-1:0] fa, input logic [DW-1:0] fd, input logic to);
    res_t r;
    r.cyc = cyc; r.vc = vc; r.err = err; r.fa = fa; r.fd = fd; r.to = to;
    res_q.push_back(r);
  endtask

  task automatic complete_txn();
    txn_t e;
    logic [DW-1:0] cur;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_txn: got addr=%h wstrb=%h, expected no request", addr_o, wstrb_o);
    end else begin
      e = exp_q.pop_front();
      if (addr_o !== e.a || wstrb_o !== e.s || (e.s != '0 && wdata_o !== e.d)) begin
        errors++;
        $display("FAIL txn: got addr=%h wstrb=%h wdata=%h, expected addr=%h wstrb=%h wdata=%h",
                 addr_o, wstrb_o, wdata_o, e.a, e.s, e.d);
      end
    end
    cur = mem.exists(addr_o) ? mem[addr_o] : '0;
    if (wstrb_o != '0) begin
      for (int j = 0; j < NB; j++)
        if (wstrb_o[j]) cur[8*j +: 8] = wdata_o[8*j +: 8];
      mem[addr_o] = cur;
    end else begin
      rdata_i = cur;
    end
  endtask

  task automatic check_done();
    res_t r;
    if (res_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: got done=1, expected no completion");
    end else begin
      r = res_q.pop_front();
      chk("cycles_to_done", 64'(ncyc - t_start), 64'(r.cyc));
      chk("req_cycles", 64'(vcnt), 64'(r.vc));
      chk("err_cnt", 64'(err_cnt_o), 64'(r.err));
      chk("first_err_addr", 64'(first_err_addr_o), 64'(r.fa));
      chk("first_err_data", 64'(first_err_data_o), 64'(r.fd));
      chk("timeout", 64'(timeout_o), 64'(r.to));
      chk("busy_in_done", 64'(busy_o), 64'd1);
      chk("leftover_txns", 64'(exp_q.size()), 64'd0);
    end
    done_seen++;
  endtask

  // Responder and monitor: drives ready/rdata for the current cycle and checks
  // whatever the DUT presents, midway between rising edges.
  always @(negedge clk) begin
    ncyc++;
    rdata_i = 32'hDEADBEEF;
    if (rst_i) begin
      lat = 0;
      ready_i = 1'b0;
      h_vld = 0;
    end else begin
      if (start_i && !busy_o) begin
        t_start = ncyc;
        vcnt = 0;
      end
      if (valid_o) begin
        if (!busy_o) begin
          errors++;
          $display("FAIL valid_without_busy: got valid=1 busy=0, expected busy=1");
        end
        if (h_vld && (addr_o !== h_addr || wdata_o !== h_wdata || wstrb_o !== h_wstrb)) begin
          errors++;
          $display("FAIL req_stable: got addr=%h wdata=%h wstrb=%h, expected addr=%h wdata=%h wstrb=%h",
                   addr_o, wdata_o, wstrb_o, h_addr, h_wdata, h_wstrb);
        end
        h_vld = 1; h_addr = addr_o; h_wdata = wdata_o; h_wstrb = wstrb_o;
        lat++;
        vcnt++;
        ready_i = !no_ready && (lat >= lat_l);
        if (ready_i) begin
          complete_txn();
          lat = 0;
          h_vld = 0;
        end
      end else begin
        lat = 0;
        h_vld = 0;
        ready_i = spurious;
      end
      if (done_o) check_done();
    end
  end

  task automatic start_seq(input logic [1:0] m, input logic [AW-1:0] b, input logic [7:0] c);
    @(posedge clk); #1;
    mode_i = m; base_i = b; count_i = c; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int seen;
    seen = done_seen;
    for (int k = 0; k < 400 && done_seen == seen; k++) @(posedge clk);
    if (done_seen == seen) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no done within 400 cycles, expected a done pulse");
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] bpat [2];
    bpat[0] = 32'h00000000;
    bpat[1] = 32'h01010101;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_addr", 64'(addr_o), 64'd0);
    chk("rst_wdata", 64'(wdata_o), 64'd0);
    chk("rst_wstrb", 64'(wstrb_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt_o), 64'd0);
    chk("rst_ferr_addr", 64'(first_err_addr_o), 64'd0);
    chk("rst_ferr_data", 64'(first_err_data_o), 64'd0);
    rst_i = 1'b0;

    // WORD, 4 words at 0x1234, ready in the first request cycle
    lat_l = 1;
    for (int i = 0; i < 4; i++) push_w(30'h1234 + 30'(i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) push_r(30'h1234 + 30'(i));
    push_res(17, 8, 2'd0, '0, '0, 1'b0);
    start_seq(M_WORD, 30'h1234, 8'd4);
    wait_done();

    // BYTE, 2 words, ready latency 2, spurious ready between requests
    lat_l = 2;
    spurious = 1;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < NB; j++) push_w(30'h100 + 30'(i), bpat[i], 4'(1 << j));
    push_r(30'h100);
    push_r(30'h101);
    push_res(31, 20, 2'd0, '0, '0, 1'b0);
    start_seq(M_BYTE, 30'h100, 8'd2);
    wait_done();
    spurious = 0;

    // READ over unwritten memory: every word mismatches
    lat_l = 1;
    for (int i = 0; i < 3; i++) push_r(30'h2000 + 30'(i));
    push_res(7, 3, 2'd3, 30'h2000, 32'h0, 1'b0);
    start_seq(M_READ, 30'h2000, 8'd3);
    wait_done();

    // READ shifted by one over the WORD data: 0x1235 holds 2, 0x1236 holds 3
    push_r(30'h1235);
    push_r(30'h1236);
    push_res(5, 2, 2'd2, 30'h1235, 32'h2, 1'b0);
    start_seq(M_READ, 30'h1235, 8'd2);
    wait_done();

    // RAW, 3 words, latency 2
    lat_l = 2;
    for (int i = 0; i < 3; i++) begin
      push_w(30'h3000 + 30'(i), 32'(i + 1), 4'hF);
      push_r(30'h3000 + 30'(i));
    end
    push_res(19, 12, 2'd0, '0, '0, 1'b0);
    start_seq(M_RAW, 30'h3000, 8'd3);
    wait_done();

    // Responder never answers: 15 request cycles then timeout
    no_ready = 1;
    push_res(16, 15, 2'd0, '0, '0, 1'b1);
    start_seq(M_WORD, 30'h4000, 8'd2);
    wait_done();
    repeat (20) @(posedge clk);
    no_ready = 0;

    // count = 0: straight to DONE, timeout cleared by start
    lat_l = 1;
    push_res(1, 0, 2'd0, '0, '0, 1'b0);
    start_seq(M_WORD, 30'h4100, 8'd0);
    wait_done();

    // error counter saturation at 3
    for (int i = 0; i < 5; i++) push_r(30'h5000 + 30'(i));
    push_res(11, 5, 2'd3, 30'h5000, 32'h0, 1'b0);
    start_seq(M_READ, 30'h5000, 8'd5);
    wait_done();

    // start while busy is ignored
    push_w(30'h6000, 32'h1, 4'hF);
    push_w(30'h6001, 32'h2, 4'hF);
    push_r(30'h6000);
    push_r(30'h6001);
    push_res(9, 4, 2'd0, '0, '0, 1'b0);
    start_seq(M_WORD, 30'h6000, 8'd2);
    @(posedge clk); #1;
    mode_i = M_READ; base_i = 30'h7000; count_i = 8'd9; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done();

    // address window wraps past the top of the word space
    push_w(30'h3FFFFFFF, 32'h1, 4'hF);
    push_w(30'h0, 32'h2, 4'hF);
    push_r(30'h3FFFFFFF);
    push_r(30'h0);
    push_res(9, 4, 2'd0, '0, '0, 1'b0);
    start_seq(M_WORD, 30'h3FFFFFFF, 8'd2);
    wait_done();

    // reset in the middle of the second REQ, after one mismatch was recorded
    lat_l = 2;
    push_r(30'h9000);
    start_seq(M_READ, 30'h9000, 8'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(valid_o), 64'd1);
    chk("pre_rst_err_cnt", 64'(err_cnt_o), 64'd1);
    chk("pre_rst_ferr_addr", 64'(first_err_addr_o), 64'h9000);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_valid", 64'(valid_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_done", 64'(done_o), 64'd0);
    chk("midrst_addr", 64'(addr_o), 64'd0);
    chk("midrst_err_cnt", 64'(err_cnt_o), 64'd0);
    chk("midrst_ferr_addr", 64'(first_err_addr_o), 64'd0);
    chk("midrst_timeout", 64'(timeout_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    chk("midrst_leftover", 64'(exp_q.size()), 64'd0);

    // normal operation after reset, latency 3
    lat_l = 3;
    push_w(30'hA000, 32'h1, 4'hF);
    push_r(30'hA000);
    push_res(9, 6, 2'd0, '0, '0, 1'b0);
    start_seq(M_WORD, 30'hA000, 8'd1);
    wait_done();

    chk("pending_results", 64'(res_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
